// File: rtl/osd_cfg_pkg.sv
// Shared constants and types for the OSD configuration command controller:
// packet framing bytes, opcodes, per-opcode lengths, status codes and FSM states.
package osd_cfg_pkg;

  localparam logic [7:0]  MAGIC_RX   = 8'hA5;
  localparam logic [7:0]  MAGIC_ACK  = 8'h5A;

  localparam logic [7:0]  OP_WINDOW  = 8'h01;
  localparam logic [7:0]  OP_CHAR    = 8'h02;
  localparam logic [7:0]  OP_ENABLE  = 8'h03;

  localparam logic [15:0] LEN_WINDOW = 16'd11;
  localparam logic [15:0] LEN_CHAR   = 16'd7;
  localparam logic [15:0] LEN_ENABLE = 16'd4;
  localparam logic [15:0] ACK_LEN    = 16'd3;

  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_BAD_MAGIC  = 3'd1,
    ST_BAD_OPCODE = 3'd2,
    ST_LENGTH     = 3'd3,
    ST_CHECKSUM   = 3'd4,
    ST_RANGE      = 3'd5
  } status_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPC,
    S_PAYLOAD,
    S_CHECK,
    S_ACK,
    S_DRAIN
  } state_t;

  // Total packet length for a known opcode, 0 for an unknown one.
  function automatic logic [15:0] op_len(input logic [7:0] op);
    case (op)
      OP_WINDOW: op_len = LEN_WINDOW;
      OP_CHAR:   op_len = LEN_CHAR;
      OP_ENABLE: op_len = LEN_ENABLE;
      default:   op_len = '0;
    endcase
  endfunction

endpackage

// File: rtl/osd_cfg_ctrl_if.sv
// UDP-side streams of osd_cfg_ctrl: rx command bytes in, 3-byte ack stream out.
interface osd_cfg_ctrl_if;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic [15:0] s_tsize;
  logic        s_tready;

  logic [7:0]  m_tx_data;
  logic        m_tx_valid;
  logic        m_tx_start;
  logic        m_tx_last;
  logic [15:0] m_tx_tsize;

  modport master (
    output s_tdata, s_tvalid, s_tlast, s_tsize,
    input  s_tready,
    input  m_tx_data, m_tx_valid, m_tx_start, m_tx_last, m_tx_tsize
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, s_tsize,
    output s_tready,
    output m_tx_data, m_tx_valid, m_tx_start, m_tx_last, m_tx_tsize
  );
endinterface

// File: rtl/osd_cfg_ack_tx.sv
// Three-byte ack serializer (0x5A, opcode, status); a kick starts the burst
// on the following cycle. Only instantiated when OSD_CFG_ACK_EN is defined.
module osd_cfg_ack_tx
  import osd_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       kick,
  input  logic [7:0] opcode,
  input  logic [2:0] status,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_start,
  output logic       tx_last
);

  logic [1:0] idx;
  logic       valid;
  logic [7:0] op_q;
  logic [2:0] st_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx   <= '0;
      valid <= 1'b0;
      op_q  <= '0;
      st_q  <= '0;
    end else if (kick) begin
      idx   <= '0;
      valid <= 1'b1;
      op_q  <= opcode;
      st_q  <= status;
    end else if (valid) begin
      if (idx == 2'd2) begin
        idx   <= '0;
        valid <= 1'b0;
      end else begin
        idx <= idx + 2'd1;
      end
    end
  end

  always_comb begin
    tx_data = '0;
    if (valid) begin
      case (idx)
        2'd0:    tx_data = MAGIC_ACK;
        2'd1:    tx_data = op_q;
        default: tx_data = {5'b0, st_q};
      endcase
    end
  end

  assign tx_valid = valid;
  assign tx_start = valid && (idx == 2'd0);
  assign tx_last  = valid && (idx == 2'd2);

endmodule

// File: rtl/osd_cfg_ctrl.sv
// UDP command parser driving the OSD window/glyph configuration through a
// vsync-committed shadow set. Define OSD_CFG_ACK_EN to emit a 3-byte ack per packet.
module osd_cfg_ctrl
  import osd_cfg_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = 1920,
  parameter int unsigned SCREEN_HEIGHT = 1080,
  parameter int unsigned DEF_CHAR_W    = 20,
  parameter int unsigned DEF_CHAR_H    = 30,
  parameter int unsigned MAX_CHAR_DIM  = 64
) (
  input  logic          clk,
  input  logic          resetn,
  osd_cfg_ctrl_if.slave udp,
  input  logic          vs_in,
  output logic [10:0]   cfg_start_posX,
  output logic [10:0]   cfg_start_posY,
  output logic [10:0]   cfg_end_posX,
  output logic [10:0]   cfg_end_posY,
  output logic [10:0]   cfg_char_width,
  output logic [10:0]   cfg_char_height,
  output logic          cfg_osd_en,
  output logic          cfg_update,
  output logic [2:0]    last_status,
  output logic [15:0]   err_count
);

`ifdef OSD_CFG_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  localparam logic [10:0] RST_EX = 11'(SCREEN_WIDTH - 1);
  localparam logic [10:0] RST_EY = 11'(SCREEN_HEIGHT - 1);
  localparam logic [10:0] RST_W  = 11'(DEF_CHAR_W);
  localparam logic [10:0] RST_H  = 11'(DEF_CHAR_H);

  state_t      state, state_nx;
  status_t     err_q, err_nx, chk_status;
  logic        ready, accept, last_byte, range_ok, wr_ok, ack_last;
  logic [15:0] tsize_q;
  logic [7:0]  op_q, xor_q;
  logic [3:0]  cnt_q;
  logic [43:0] pay_q;
  logic [10:0] f_sx, f_sy, f_ex, f_ey;
  logic        vs_q, vs_rise, pending, commit;
  logic [10:0] sh_sx, sh_sy, sh_ex, sh_ey, sh_w, sh_h;
  logic        sh_en;

  assign accept        = udp.s_tvalid && ready;
  assign udp.s_tready  = ready;
  assign last_byte     = ({12'd0, cnt_q} + 16'd1) == op_len(op_q);

  // Payload keeps only the low 11 bits of each 16-bit field, packed {sx,sy,ex,ey};
  // the char packet lands in the ex/ey slots and the enable bit in bit 0.
  assign f_sx = pay_q[43:33];
  assign f_sy = pay_q[32:22];
  assign f_ex = pay_q[21:11];
  assign f_ey = pay_q[10:0];

  always_comb begin
    range_ok = 1'b0;
    case (op_q)
      OP_WINDOW: range_ok = (f_sx < f_ex) && (32'(f_ex) < SCREEN_WIDTH) &&
                            (f_sy < f_ey) && (32'(f_ey) < SCREEN_HEIGHT);
      OP_CHAR:   range_ok = (f_ex != '0) && (32'(f_ex) <= MAX_CHAR_DIM) &&
                            (f_ey != '0) && (32'(f_ey) <= MAX_CHAR_DIM);
      OP_ENABLE: range_ok = 1'b1;
      default:   range_ok = 1'b0;
    endcase
  end

  always_comb begin
    chk_status = err_q;
    if (err_q == ST_OK) begin
      if (xor_q != '0)    chk_status = ST_CHECKSUM;
      else if (!range_ok) chk_status = ST_RANGE;
    end
  end

  assign wr_ok = (state == S_CHECK) && (chk_status == ST_OK);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      err_q <= ST_OK;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    ready    = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (accept) begin
          if (udp.s_tdata != MAGIC_RX) begin
            err_nx   = ST_BAD_MAGIC;
            state_nx = udp.s_tlast ? S_CHECK : S_DRAIN;
          end else if (udp.s_tlast) begin
            err_nx   = ST_LENGTH;
            state_nx = S_CHECK;
          end else begin
            err_nx   = ST_OK;
            state_nx = S_OPC;
          end
        end
      end
      S_OPC: begin
        ready = 1'b1;
        if (accept) begin
          if (op_len(udp.s_tdata) == '0) begin
            err_nx   = ST_BAD_OPCODE;
            state_nx = udp.s_tlast ? S_CHECK : S_DRAIN;
          end else if (tsize_q != op_len(udp.s_tdata)) begin
            err_nx   = ST_LENGTH;
            state_nx = udp.s_tlast ? S_CHECK : S_DRAIN;
          end else if (udp.s_tlast) begin
            err_nx   = ST_LENGTH;
            state_nx = S_CHECK;
          end else begin
            state_nx = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        ready = 1'b1;
        if (accept) begin
          if (last_byte) begin
            state_nx = udp.s_tlast ? S_CHECK : S_DRAIN;
            if (!udp.s_tlast) err_nx = ST_LENGTH;
          end else if (udp.s_tlast) begin
            err_nx   = ST_LENGTH;
            state_nx = S_CHECK;
          end
        end
      end
      S_CHECK: state_nx = ACK_EN ? S_ACK : S_IDLE;
      S_ACK:   if (ack_last) state_nx = S_IDLE;
      S_DRAIN: begin
        ready = 1'b1;
        if (accept && udp.s_tlast) state_nx = S_CHECK;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tsize_q     <= '0;
      op_q        <= '0;
      xor_q       <= '0;
      cnt_q       <= '0;
      pay_q       <= '0;
      last_status <= '0;
      err_count   <= '0;
    end else begin
      if (accept) begin
        xor_q <= (state == S_IDLE) ? udp.s_tdata : (xor_q ^ udp.s_tdata);
        cnt_q <= (state == S_IDLE) ? 4'd1 : (cnt_q + 4'd1);
        if (state == S_IDLE) begin
          tsize_q <= udp.s_tsize;
          op_q    <= '0;
        end
        if (state == S_OPC) op_q <= udp.s_tdata;
        // Even byte counts are field high bytes: only their 3 low bits matter.
        if (state == S_PAYLOAD && !last_byte) begin
          if (!cnt_q[0]) pay_q <= {pay_q[40:0], udp.s_tdata[2:0]};
          else           pay_q <= {pay_q[35:0], udp.s_tdata};
        end
      end
      if (state == S_CHECK) begin
        last_status <= chk_status;
        if (chk_status != ST_OK && err_count != '1) err_count <= err_count + 16'd1;
      end
    end
  end

  assign commit = vs_rise && pending;

  // A write landing on the commit cycle goes to shadow after the old shadow is copied out.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vs_q            <= 1'b0;
      vs_rise         <= 1'b0;
      pending         <= 1'b0;
      cfg_update      <= 1'b0;
      sh_sx           <= '0;
      sh_sy           <= '0;
      sh_ex           <= RST_EX;
      sh_ey           <= RST_EY;
      sh_w            <= RST_W;
      sh_h            <= RST_H;
      sh_en           <= 1'b1;
      cfg_start_posX  <= '0;
      cfg_start_posY  <= '0;
      cfg_end_posX    <= RST_EX;
      cfg_end_posY    <= RST_EY;
      cfg_char_width  <= RST_W;
      cfg_char_height <= RST_H;
      cfg_osd_en      <= 1'b1;
    end else begin
      vs_q       <= vs_in;
      vs_rise    <= vs_in && !vs_q;
      cfg_update <= commit;
      if (commit) begin
        cfg_start_posX  <= sh_sx;
        cfg_start_posY  <= sh_sy;
        cfg_end_posX    <= sh_ex;
        cfg_end_posY    <= sh_ey;
        cfg_char_width  <= sh_w;
        cfg_char_height <= sh_h;
        cfg_osd_en      <= sh_en;
      end
      if (wr_ok) begin
        case (op_q)
          OP_WINDOW: begin
            sh_sx <= f_sx;
            sh_sy <= f_sy;
            sh_ex <= f_ex;
            sh_ey <= f_ey;
          end
          OP_CHAR: begin
            sh_w <= f_ex;
            sh_h <= f_ey;
          end
          default: sh_en <= pay_q[0];
        endcase
      end
      if (wr_ok)       pending <= 1'b1;
      else if (commit) pending <= 1'b0;
    end
  end

  assign udp.m_tx_tsize = ACK_LEN;

`ifdef OSD_CFG_ACK_EN
  osd_cfg_ack_tx u_ack_tx (
    .clk      (clk),
    .resetn   (resetn),
    .kick     (state == S_CHECK),
    .opcode   (op_q),
    .status   (chk_status),
    .tx_data  (udp.m_tx_data),
    .tx_valid (udp.m_tx_valid),
    .tx_start (udp.m_tx_start),
    .tx_last  (udp.m_tx_last)
  );
  assign ack_last = udp.m_tx_last;
`else
  assign udp.m_tx_data  = '0;
  assign udp.m_tx_valid = 1'b0;
  assign udp.m_tx_start = 1'b0;
  assign udp.m_tx_last  = 1'b0;
  assign ack_last       = 1'b0;
`endif

endmodule
